// File: rtl/mgmt_data_channel_req_tracker.sv
// mgmt_data_channel_req_tracker
//   Sits between the management host bridge and mgmt_data_channel_controller.
//   Host requests are queued in a small FIFO. Each one is stamped with a rolling
//   tag when it is popped, and then issued on the controller's valid/ack
//   handshake. Only one request is outstanding at a time. Every issued request
//   produces exactly one host response: the tag-matched controller frame, or a
//   synthesized error frame on timeout or link loss.
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   host_req_valid/ready    host request handshake (ready = FIFO not full)
//   host_req                host payload (incoming tag ignored)
//   host_res_valid/host_res one-cycle response pulse + payload
//   dc_req_valid/ack/dc_req request side of the controller
//   dc_res_valid/dc_res     response side of the controller
//   local_link_state        PHY link state; only operational_st allows traffic
//   data_channel_rst        sync flush: FIFO emptied, FSM to IDLE, no response
//   fifo_level              FIFO occupancy
//   timeout_cnt, stale_cnt  saturating event counters

package mgmt_data_channel_pkg;
  typedef enum logic [1:0] {
    disabled_st, training_st, operational_st, error_st
  } link_state_t;

  typedef enum logic [1:0] {
    READ_CMD, WRITE_CMD, CRC_ERROR, NOP_CMD
  } command_t;

  localparam int TAG_W = 4;

  typedef struct packed {
    command_t         command;
    logic [15:0]      address;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             operation_status;
  } Data_channel_payload_t;
endpackage

module mgmt_data_channel_req_tracker
  import mgmt_data_channel_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          host_req_valid,
  output logic                          host_req_ready,
  input  Data_channel_payload_t         host_req,
  output logic                          host_res_valid,
  output Data_channel_payload_t         host_res,
  output logic                          dc_req_valid,
  input  logic                          dc_req_ack,
  output Data_channel_payload_t         dc_req,
  input  logic                          dc_res_valid,
  input  Data_channel_payload_t         dc_res,
  input  link_state_t                   local_link_state,
  input  logic                          data_channel_rst,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   timeout_cnt,
  output logic [15:0]                   stale_cnt
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int WCW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, RESP} state_t;

  state_t                state, state_nxt;
  Data_channel_payload_t mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [TAG_W-1:0]      tag_cnt;
  logic [WCW-1:0]        wait_cnt;

  logic                  push, pop;
  logic                  link_ok, tag_match, timeout_now;
  logic                  res_load, res_synth, timeout_hit, stale_hit;
  Data_channel_payload_t issue_req, synth_res;

  assign link_ok        = (local_link_state == operational_st);
  assign host_req_ready = (fifo_level != LW'(FIFO_DEPTH));
  // A flush in the same cycle discards the incoming request too.
  assign push           = host_req_valid && host_req_ready && !data_channel_rst;
  assign dc_req_valid   = (state == ISSUE);
  assign tag_match      = dc_res_valid && (dc_res.tag == dc_req.tag);
  assign timeout_now    = (wait_cnt == WCW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    issue_req     = mem[rd_ptr];
    issue_req.tag = tag_cnt;
    synth_res                  = dc_req;
    synth_res.operation_status = 1'b1;
    synth_res.data             = '0;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    res_load    = 1'b0;
    res_synth   = 1'b0;
    timeout_hit = 1'b0;
    stale_hit   = 1'b0;
    case (state)
      IDLE: if (fifo_level != '0 && link_ok) begin
        pop       = 1'b1;
        state_nxt = ISSUE;
      end
      // Link loss aborts the request even if ack arrives in the same cycle.
      ISSUE: if (!link_ok) begin
        res_synth = 1'b1;
        state_nxt = RESP;
      end else if (dc_req_ack) begin
        state_nxt = WAIT_RES;
      end
      // Priority: matching response > link loss > timeout.
      WAIT_RES: begin
        stale_hit = dc_res_valid && !tag_match;
        if (tag_match) begin
          res_load  = 1'b1;
          state_nxt = RESP;
        end else if (!link_ok) begin
          res_synth = 1'b1;
          state_nxt = RESP;
        end else if (timeout_now) begin
          res_synth   = 1'b1;
          timeout_hit = 1'b1;
          state_nxt   = RESP;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (data_channel_rst) begin
      state_nxt   = IDLE;
      pop         = 1'b0;
      res_load    = 1'b0;
      res_synth   = 1'b0;
      timeout_hit = 1'b0;
      stale_hit   = 1'b0;
    end
  end

  // ---------------- FIFO ----------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host_req;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (data_channel_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dc_req         <= '0;
      tag_cnt        <= '0;
      wait_cnt       <= '0;
      host_res       <= '0;
      host_res_valid <= 1'b0;
      timeout_cnt    <= '0;
      stale_cnt      <= '0;
    end else begin
      if (pop) begin
        dc_req  <= issue_req;
        tag_cnt <= tag_cnt + TAG_W'(1);
      end
      // Zero on every cycle outside WAIT_RES, so it reads 0 on entry.
      if (state != WAIT_RES) wait_cnt <= '0;
      else                   wait_cnt <= wait_cnt + WCW'(1);
      if (res_load)       host_res <= dc_res;
      else if (res_synth) host_res <= synth_res;
      // The response pulse follows the RESP cycle so host_res is settled.
      host_res_valid <= (state == RESP) && !data_channel_rst;
      if (timeout_hit && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
      if (stale_hit && stale_cnt != 16'hFFFF)     stale_cnt   <= stale_cnt + 16'd1;
    end
  end

endmodule
